// File: rtl/score_keeper_pkg.sv
// Shared game-state codes and a saturating counter helper for score_keeper
// and the display stages that decode its state bus.
package score_keeper_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PLAY  = 3'd1;
    localparam logic [2:0] PAUSE = 3'd2;
    localparam logic [2:0] WIN   = 3'd3;
    localparam logic [2:0] LOSE  = 3'd4;

    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Key/target inputs and state/counter outputs of the score keeper.
interface score_keeper_if #(
    parameter int N_KEYS = 4
);

    logic              start_key;
    logic              pause_key;
    logic [N_KEYS-1:0] hit_key;
    logic [N_KEYS-1:0] target;
    logic [2:0]        state;
    logic [3:0]        score;
    logic [3:0]        miss;
    logic              hit_pulse;
    logic              miss_pulse;

    modport master (
        output start_key, pause_key, hit_key, target,
        input  state, score, miss, hit_pulse, miss_pulse
    );

    modport slave (
        input  start_key, pause_key, hit_key, target,
        output state, score, miss, hit_pulse, miss_pulse
    );

endinterface

// File: rtl/score_keeper_key_edge.sv
// Registers a debounced key vector and emits a registered one-cycle strobe
// per rising edge, so a held key yields exactly one press.
module score_keeper_key_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_i,
    output logic [W-1:0] press_o
);

    logic [W-1:0] key_q;
    logic [W-1:0] press_q;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q   <= '0;
            press_q <= '0;
        end else begin
            key_q   <= key_i;
            press_q <= key_i & ~key_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/score_keeper.sv
// Game FSM plus hit/miss judging of key presses against the target lamps.
// Presses arrive one clock late, so they are judged against target_q.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE = 9,
    parameter int MAX_MISS  = 5,
    parameter int N_KEYS    = 4
) (
    input logic           clk,
    input logic           rst,
    score_keeper_if.slave bus
);

    localparam logic [3:0] WIN_LIM  = 4'(WIN_SCORE);
    localparam logic [3:0] MISS_LIM = 4'(MAX_MISS);

    logic              start_p;
    logic              pause_p;
    logic [N_KEYS-1:0] hit_p;

    logic [2:0]        state_q, state_d;
    logic [3:0]        score_q, score_d;
    logic [3:0]        miss_q, miss_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic              judged_q, judged_d;
    logic [N_KEYS-1:0] target_q;

    logic new_win, judging, hit_ev, wrong_ev, expire_ev, go_play;

    score_keeper_key_edge #(.W(1)) u_start_edge (
        .clk(clk), .rst(rst), .key_i(bus.start_key), .press_o(start_p)
    );
    score_keeper_key_edge #(.W(1)) u_pause_edge (
        .clk(clk), .rst(rst), .key_i(bus.pause_key), .press_o(pause_p)
    );
    score_keeper_key_edge #(.W(N_KEYS)) u_hit_edge (
        .clk(clk), .rst(rst), .key_i(bus.hit_key), .press_o(hit_p)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        new_win   = (bus.target != target_q);
        judging   = (state_q == PLAY) && (score_q != WIN_LIM) && (miss_q != MISS_LIM);
        hit_ev    = judging && !judged_q && (|(hit_p & target_q));
        wrong_ev  = judging && (|(hit_p & ~target_q));
        // A closing window that is hit in its final cycle is not also an expiry.
        expire_ev = judging && !judged_q && (|target_q) && new_win && !hit_ev;

        state_d      = state_q;
        score_d      = hit_ev ? sat_inc(score_q, WIN_LIM) : score_q;
        miss_d       = (wrong_ev || expire_ev) ? sat_inc(miss_q, MISS_LIM) : miss_q;
        hit_pulse_d  = hit_ev;
        miss_pulse_d = wrong_ev || expire_ev;
        judged_d     = new_win ? 1'b0 : (judged_q || hit_ev);
        go_play      = 1'b0;

        case (state_q)
            IDLE:      go_play = start_p;
            PLAY: begin
                if (score_q == WIN_LIM)      state_d = WIN;
                else if (miss_q == MISS_LIM) state_d = LOSE;
                else if (pause_p)            state_d = PAUSE;
            end
            PAUSE: begin
                if (start_p)      state_d = IDLE;
                else if (pause_p) state_d = PLAY;
            end
            WIN, LOSE: go_play = start_p;
            default:   state_d = IDLE;
        endcase

        if (go_play) begin
            state_d  = PLAY;
            score_d  = '0;
            miss_d   = '0;
            judged_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            score_q      <= '0;
            miss_q       <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            judged_q     <= 1'b0;
            target_q     <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            miss_q       <= miss_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            judged_q     <= judged_d;
            target_q     <= bus.target;
        end
    end

    assign bus.state      = state_q;
    assign bus.score      = score_q;
    assign bus.miss       = miss_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Judges player key presses against the active target lamp pattern and counts hits and misses.
- Runs the game state machine.
- Drives the `state[2:0]`, `score[3:0]` and `miss[3:0]` buses consumed by the downstream feedback stage (tri-colour LED flasher), the seven-segment display and the target generator.
- Sits between the debounced key inputs / target generator and all display stages.

Parameters:
- WIN_SCORE, 9, score value that ends the game as a win (1..15)
- MAX_MISS, 5, miss value that ends the game as a loss (1..15)
- N_KEYS, 4, number of target lamps / hit keys

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start_key  input  1  debounced start/restart button, level
- pause_key  input  1  debounced pause toggle button, level
- hit_key  input  N_KEYS  debounced hit buttons, level, one per lamp
- target  input  N_KEYS  one-hot lamp pattern from target generator; all-zero = no window open
- state  output  3  game state code
- score  output  4  hit count
- miss  output  4  miss count
- hit_pulse  output  1  one-cycle strobe per scored hit
- miss_pulse  output  1  one-cycle strobe per counted miss

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst; all flops clear on negedge rst, with no synchronous reset path.
- Reset values:
  - state = IDLE (3'd0); score = 0; miss = 0; hit_pulse = 0; miss_pulse = 0.
  - Edge-detect registers = 0; judged flag = 0; target_q = 0.
- Edge detection:
  - start_key, pause_key and each hit_key bit are registered once.
  - A press is the cycle where input = 1 and registered copy = 0.
  - Held keys produce exactly one press.
- State codes: IDLE = 0, PLAY = 1, PAUSE = 2, WIN = 3, LOSE = 4. Codes 5–7 are illegal and return to IDLE on the next clock.
- Transitions:
  - IDLE: start press -> PLAY. Entering PLAY clears score, miss and the judged flag.
  - PLAY: pause press -> PAUSE. Game-end conditions -> WIN or LOSE (see end rule).
  - PAUSE: pause press -> PLAY. Start press -> IDLE. No judging while paused.
  - WIN / LOSE: start press -> PLAY, with counters cleared. Score and miss hold their final values until then.
- Judging (PLAY only):
  - Window: target != 0. A window is "new" when target differs from target_q; a new window clears the judged flag.
  - Hit: a hit-key press whose bit matches target while the window is open and judged = 0.
    - score += 1; hit_pulse = 1; judged = 1.
  - Wrong key: a press on a non-target key, or any press while no window is open.
    - miss += 1; miss_pulse = 1.
  - Repeat press: a press of the correct key after judged = 1 is ignored (no count).
  - Expired window: target_q != 0, judged = 0, and target changes (to 0 or another lamp).
    - miss += 1; miss_pulse = 1.
- Simultaneous events within one cycle:
  - Correct press in the same cycle the window closes: counted as a hit; no expiry miss.
  - Correct and wrong presses together: one hit and one miss, both pulses high.
  - Several wrong presses together: count as one miss.
  - Hit and miss in the same cycle both apply; both pulses high.
- Latency: key edge at input -> counter and pulse update 2 clocks later (1 sync register + 1 output register). All outputs are registered.
- Width and end rule:
  - score and miss never exceed WIN_SCORE and MAX_MISS respectively; they saturate there.
  - In the cycle after score reaches WIN_SCORE: state = WIN.
  - Else, in the cycle after miss reaches MAX_MISS: state = LOSE.
  - If both thresholds are reached in the same cycle, WIN has priority.
- Reset mid-game: immediate return to IDLE with counters cleared. No pulse is emitted during or after reset release.
- Outside PLAY, hit presses and target changes produce no counts and no pulses; target_q still tracks target.

Decomposition:
- Shared package: state codes IDLE/PLAY/PAUSE/WIN/LOSE as 3-bit localparams. The downstream LED and display stages use the same constants.
- One sub-module is natural: key_edge (register + rising-edge detect, width parameter), instantiated for the start, pause and hit keys.

Test Plan:
- Reset with rst=0 mid-PLAY at score=3 -> state=0, score=0, miss=0 immediately; no pulses after rst=1.
- IDLE, start press, target=4'b0010, press hit_key[1] -> state=1; score=1 and hit_pulse high for 1 cycle, 2 clocks after the edge; holding the key gives no further counts.
- target=4'b0100 then target->0 with no press -> miss=1, one miss_pulse. Next, press hit_key[0] while target=0 -> miss=2.
- Correct press in the same cycle target changes 4'b1000->4'b0001 -> score+1, miss unchanged. Then press hit_key[0] and hit_key[2] together -> score+1 and miss+1 in the same cycle.
- Score 8 -> hit -> score=9, state=3 next cycle, further presses ignored. Start press -> state=1, score=0, miss=0. With MAX_MISS=5, five wrong presses -> miss=5, state=4.
- PLAY, pause press -> state=2; a target change and key presses produce no counts. Pause press -> state=1. In PAUSE, start press -> state=0.
